fir_tap_loader: RTL and testbench
=================================

# fir_tap_loader

Upstream sample-loading stage for the FIR core FSM. Captures 8-bit samples from the chip input pins on a strobe, maintains the 5-tap delay line presented to the core's `input_0..input_4`, and sequences one filter pass per sample. Each pass issues a start pulse, sweeps the tap selector, then waits for the core's completion. Flags overruns and core time-outs for debug readout on the bidirectional pins.

## Interface
Parameters:
- `DATA_W`, 8, sample and tap width
- `TAPS`, 5, delay-line depth; fixed at 5 for this design
- `TIMEOUT`, 255, maximum cycles to wait for `done` before aborting

Ports:
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `in_strobe`  in  1  sample strobe from pin; asynchronous; rising edge marks a new sample
- `in_data`  in  DATA_W  sample byte; source holds it stable from strobe rise for ≥4 cycles
- `done`  in  1  core pass complete; single-cycle pulse
- `tap_0`..`tap_4`  out  DATA_W each  delay line; `tap_0` is the newest sample
- `x_dat`  out  DATA_W  newest accepted sample; drives the core's `x_rsc_dat`
- `start`  out  1  one-cycle pulse; drives the core's `Shift_Accum_Loop_C_0_tr0`
- `sel`  out  3  tap index 0..4 during the sweep
- `sel_valid`  out  1  high while `sel` carries a live index
- `busy`  out  1  state ≠ IDLE
- `overrun`  out  1  sticky; a strobe edge arrived while busy
- `timeout`  out  1  sticky; `done` not received within `TIMEOUT` cycles
- `drop_cnt`  out  8  count of dropped samples; saturates at 255

## Operation
- Strobe conditioning:
  - 3-flop chain s1→s2→s3 on `in_strobe`
  - `edge` = s2 & ~s3 (combinational from registered stages)
  - One `edge` per rising transition; strobe held high never re-triggers
- States: IDLE, START, SCAN, WAIT. Reset state is IDLE.
- IDLE, on `edge`:
  - Shift the delay line: tap_4←tap_3, tap_3←tap_2, tap_2←tap_1, tap_1←tap_0, tap_0←`in_data`
  - `x_dat`←`in_data`
  - Go to START
- START:
  - `start`=1 for exactly this cycle; `sel`=0; `sel_valid`=0
  - Go to SCAN
- SCAN:
  - `sel_valid`=1; `sel` steps 0,1,2,3,4, one value per cycle
  - After `sel`=4, go to WAIT with `sel` reset to 0
- WAIT:
  - Cycle counter starts at 0 on entry
  - On `done`: go to IDLE
  - Counter reaching `TIMEOUT` with no `done`: set `timeout`, go to IDLE; taps are retained
- `done` seen in IDLE, START or SCAN is ignored and has no side effects.
- `edge` in any state other than IDLE:
  - Sample dropped; taps and `x_dat` unchanged
  - `overrun`←1; `drop_cnt` increments, saturating at 255
- `edge` on the same cycle WAIT exits to IDLE is dropped (counted as overrun). The sample is accepted only when IDLE is the current state.
- `overrun`, `timeout` and `drop_cnt` clear only on `rst`.
- Reset values: all taps, `x_dat`, `sel`, `drop_cnt` = 0. `start`, `sel_valid`, `busy`, `overrun`, `timeout` = 0. Synchronizer flops = 0.
- `rst` mid-operation, in any state: next cycle is IDLE with all reset values. A strobe held high across reset release produces one `edge` once s2 rises.

## Timing
- `in_strobe` first sampled high at edge E0 → s1=1 after E0, s2=1 after E1, so `edge` is high in the cycle after E1.
- Taps and `x_dat` update at E2. `start` is high in the cycle after E2.
- `sel`=0..4 with `sel_valid` in the 5 cycles after `start`. WAIT begins the following cycle.
- Minimum pass: 1 (START) + 5 (SCAN) + 1 (WAIT, if `done` is immediate) = 7 cycles from tap update to IDLE.
- Sustained rate: one sample per 8 cycles maximum, including the IDLE cycle.
- `start` and `sel_valid` are never high together. `busy` rises at E2, together with the tap update.

## Test plan
- Reset, then idle 20 cycles → all outputs 0; `busy`=0; no `start`.
- Single strobe, `in_data`=0xAA, `done` returned 2 cycles after `sel`=4 → `tap_0`=`x_dat`=0xAA, other taps 0. One `start` pulse. `sel` sequence 0,1,2,3,4. `busy` falls after `done`.
- Five samples 0x01..0x05, each pass completed → `tap_0..tap_4` = 05,04,03,02,01. A sixth sample 0x06 gives 06,05,04,03,02.
- Strobe during SCAN → taps unchanged; `overrun`=1; `drop_cnt`=1. 300 extra strobes → `drop_cnt` saturates at 255.
- `done` never returned → `timeout`=1 exactly `TIMEOUT` cycles after WAIT entry; state is IDLE; the next strobe is accepted.
- `rst` asserted during SCAN with `sel`=2 → all outputs 0 the next cycle. `in_strobe` held high through reset release → exactly one sample accepted.

Source files
------------

// File: rtl/fir_tap_loader.sv
// Sample loader ahead of the FIR core: synchronises the pin strobe, shifts the
// 5-tap delay line, and sequences one start/sweep/wait pass for each sample.
module fir_tap_loader #(
  parameter int DATA_W  = 8,
  parameter int TAPS    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_strobe,
  input  logic [DATA_W-1:0] in_data,
  input  logic              done,
  output logic [DATA_W-1:0] tap_0,
  output logic [DATA_W-1:0] tap_1,
  output logic [DATA_W-1:0] tap_2,
  output logic [DATA_W-1:0] tap_3,
  output logic [DATA_W-1:0] tap_4,
  output logic [DATA_W-1:0] x_dat,
  output logic              start,
  output logic [2:0]        sel,
  output logic              sel_valid,
  output logic              busy,
  output logic              overrun,
  output logic              timeout,
  output logic [7:0]        drop_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, SCAN, WAIT} state_t;

  state_t                   state_reg, state_next;
  logic                     s1_reg, s2_reg, s3_reg;
  logic                     strobe_edge;
  logic [TAPS*DATA_W-1:0]   line_reg;
  logic [DATA_W-1:0]        x_dat_reg;
  logic [2:0]               sel_reg, sel_next;
  logic [CNT_W-1:0]         wait_cnt_reg, wait_cnt_next;
  logic                     timeout_reg, timeout_next;
  logic                     overrun_reg;
  logic [7:0]               drop_cnt_reg;
  logic                     accept;
  logic [DATA_W-1:0]        tap_w [TAPS];

  // s1 is the metastability catcher; the edge is taken between s2 and s3
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= in_strobe;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign strobe_edge = s2_reg & ~s3_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sel_reg      <= 3'd0;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = timeout_reg;
    start         = 1'b0;
    sel_valid     = 1'b0;
    accept        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (strobe_edge) begin
          accept     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        start      = 1'b1;
        sel_next   = 3'd0;
        state_next = SCAN;
      end
      SCAN: begin
        sel_valid = 1'b1;
        if (sel_reg == 3'(TAPS - 1)) begin
          sel_next      = 3'd0;
          wait_cnt_next = '0;
          state_next    = WAIT;
        end else begin
          sel_next = sel_reg + 3'd1;
        end
      end
      WAIT: begin
        // wait_cnt counts WAIT cycles already spent; abort on the last allowed one
        if (done) begin
          state_next = IDLE;
        end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Delay line packed newest-first: lowest slice is tap_0
  always_ff @(posedge clk) begin
    if (rst) begin
      line_reg  <= '0;
      x_dat_reg <= '0;
    end else if (accept) begin
      line_reg  <= {line_reg[(TAPS-1)*DATA_W-1:0], in_data};
      x_dat_reg <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_reg  <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else if (strobe_edge && state_reg != IDLE) begin
      overrun_reg <= 1'b1;
      if (drop_cnt_reg != 8'hFF) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      assign tap_w[gi] = line_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign tap_0     = tap_w[0];
  assign tap_1     = tap_w[1];
  assign tap_2     = tap_w[2];
  assign tap_3     = tap_w[3];
  assign tap_4     = tap_w[4];
  assign x_dat     = x_dat_reg;
  assign sel       = sel_reg;
  assign busy      = (state_reg != IDLE);
  assign overrun   = overrun_reg;
  assign timeout   = timeout_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Bench for fir_tap_loader: a timeline model (cycles since sample acceptance)
// predicts every output each cycle; directed scenarios add literal checks.
module tb_fir_tap_loader;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_strobe = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              done = 1'b0;
  logic [DATA_W-1:0] tap_0, tap_1, tap_2, tap_3, tap_4, x_dat;
  logic              start, sel_valid, busy, overrun, timeout;
  logic [2:0]        sel;
  logic [7:0]        drop_cnt;

  always #5 clk = ~clk;

  fir_tap_loader #(.DATA_W(DATA_W), .TAPS(5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_strobe(in_strobe), .in_data(in_data), .done(done),
    .tap_0(tap_0), .tap_1(tap_1), .tap_2(tap_2), .tap_3(tap_3), .tap_4(tap_4),
    .x_dat(x_dat), .start(start), .sel(sel), .sel_valid(sel_valid), .busy(busy),
    .overrun(overrun), .timeout(timeout), .drop_cnt(drop_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: phase = cycles since acceptance (-1 idle, 0 start, 1..5 sweep, 6+ wait)
  int m_taps[5];
  int m_x = 0;
  int m_phase = -1;
  int m_drop = 0;
  bit m_over = 0;
  bit m_tout = 0;
  bit hist[3];   // strobe as seen at the last three clock edges, [0] newest

  task automatic model_step();
    bit e;
    e = hist[1] && !hist[2];
    if (rst) begin
      for (int i = 0; i < 5; i++) m_taps[i] = 0;
      m_x = 0; m_phase = -1; m_drop = 0; m_over = 0; m_tout = 0;
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
    end else begin
      if (m_phase < 0) begin
        if (e) begin
          for (int i = 4; i > 0; i--) m_taps[i] = m_taps[i-1];
          m_taps[0] = int'(in_data);
          m_x = int'(in_data);
          m_phase = 0;
        end
      end else begin
        if (e) begin
          m_over = 1;
          if (m_drop < 255) m_drop++;
        end
        if (m_phase >= 6) begin
          if (done) m_phase = -1;
          else if (m_phase - 6 == TIMEOUT - 1) begin
            m_tout = 1;
            m_phase = -1;
          end else m_phase++;
        end else begin
          m_phase++;
        end
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = in_strobe;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  bit chk_on = 0;
  int n_start = 0;
  int sel_log[$];

  always @(negedge clk) begin
    if (chk_on) begin
      chk("tap_0", int'(tap_0), m_taps[0]);
      chk("tap_1", int'(tap_1), m_taps[1]);
      chk("tap_2", int'(tap_2), m_taps[2]);
      chk("tap_3", int'(tap_3), m_taps[3]);
      chk("tap_4", int'(tap_4), m_taps[4]);
      chk("x_dat", int'(x_dat), m_x);
      chk("start", int'(start), int'(m_phase == 0));
      chk("sel_valid", int'(sel_valid), int'(m_phase >= 1 && m_phase <= 5));
      chk("sel", int'(sel), (m_phase >= 1 && m_phase <= 5) ? m_phase - 1 : 0);
      chk("busy", int'(busy), int'(m_phase >= 0));
      chk("overrun", int'(overrun), int'(m_over));
      chk("timeout", int'(timeout), int'(m_tout));
      chk("drop_cnt", int'(drop_cnt), m_drop);
      if (start) n_start++;
      if (sel_valid) sel_log.push_back(int'(sel));
    end
  end

  // Core stand-in: pulse done done_delay cycles after the sel=4 cycle (0 = never)
  int done_delay = 1;
  bit stray_en = 0;
  int cd = 0;
  initial begin
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) done = 1'b1;
      end
      if (stray_en && $urandom_range(0, 15) == 0) done = 1'b1;
      if (sel_valid && sel == 3'd4 && done_delay > 0) cd = done_delay;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] d, input int hi, input int lo);
    @(negedge clk);
    in_data = d;
    in_strobe = 1'b1;
    repeat (hi) @(negedge clk);
    in_strobe = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({"idle_", name}, int'(busy), 0);
  endtask

  task automatic wait_sel(input int v, input string name);
    int n;
    n = 0;
    while (!(sel_valid && sel == 3'(v)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({"reach_sel_", name}, int'(sel), v);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 5; i++) m_taps[i] = 0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    rst = 1'b0;
    cyc(20);
    chk("idle_tap_0", int'(tap_0), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_starts", n_start, 0);

    // single sample, done two cycles after sel=4
    done_delay = 2;
    sel_log.delete();
    n_start = 0;
    pulse(8'hAA, 4, 4);
    wait_idle("single");
    chk("single_tap_0", int'(tap_0), 8'hAA);
    chk("single_x_dat", int'(x_dat), 8'hAA);
    chk("single_tap_1", int'(tap_1), 0);
    chk("single_starts", n_start, 1);
    chk("single_sel_len", sel_log.size(), 5);
    for (int i = 0; i < 5 && i < sel_log.size(); i++) chk("single_sel_seq", sel_log[i], i);

    // five samples then a sixth
    done_delay = 1;
    for (int d = 1; d <= 5; d++) begin
      pulse(8'(d), 4, 4);
      wait_idle("fill");
    end
    chk("fill_tap_0", int'(tap_0), 5);
    chk("fill_tap_2", int'(tap_2), 3);
    chk("fill_tap_4", int'(tap_4), 1);
    pulse(8'h06, 4, 4);
    wait_idle("sixth");
    chk("sixth_tap_0", int'(tap_0), 6);
    chk("sixth_tap_4", int'(tap_4), 2);

    // second strobe lands during the sweep
    @(negedge clk);
    in_data = 8'h77; in_strobe = 1'b1;
    cyc(3);
    in_strobe = 1'b0;
    cyc(1);
    in_data = 8'h99; in_strobe = 1'b1;
    cyc(3);
    in_strobe = 1'b0;
    cyc(4);
    wait_idle("overrun");
    chk("ovr_tap_0", int'(tap_0), 8'h77);
    chk("ovr_tap_1", int'(tap_1), 6);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_drop", int'(drop_cnt), 1);

    // strobe storm saturates the drop counter
    in_data = 8'h10;
    repeat (600) begin
      @(negedge clk) in_strobe = 1'b1;
      @(negedge clk) in_strobe = 1'b0;
    end
    cyc(4);
    wait_idle("storm");
    chk("storm_drop_sat", int'(drop_cnt), 255);

    // core never answers
    done_delay = 0;
    chk("pre_timeout", int'(timeout), 0);
    @(negedge clk);
    in_data = 8'h3C; in_strobe = 1'b1;
    cyc(4);
    in_strobe = 1'b0;
    wait_sel(4, "timeout");
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (timeout) break;
      n++;
    end
    chk("timeout_latency", n, TIMEOUT);
    chk("timeout_busy", int'(busy), 0);
    chk("timeout_tap_0", int'(tap_0), 8'h3C);
    done_delay = 1;
    pulse(8'hC3, 4, 4);
    wait_idle("after_timeout");
    chk("after_to_tap_0", int'(tap_0), 8'hC3);
    chk("after_to_tap_1", int'(tap_1), 8'h3C);

    // reset mid-sweep with the strobe held high across release
    @(negedge clk);
    in_data = 8'h5A; in_strobe = 1'b1;
    wait_sel(2, "rst");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tap_0", int'(tap_0), 0);
    chk("rst_x_dat", int'(x_dat), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_sel_valid", int'(sel_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    n_start = 0;
    cyc(12);
    in_strobe = 1'b0;
    cyc(2);
    wait_idle("rst_hold");
    chk("hold_starts", n_start, 1);
    chk("hold_tap_0", int'(tap_0), 8'h5A);
    chk("hold_tap_1", int'(tap_1), 0);

    // randomized traffic with stray done pulses
    stray_en = 1;
    repeat (150) begin
      done_delay = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 5));
      pulse(8'($urandom), int'($urandom_range(1, 5)), int'($urandom_range(1, 12)));
    end
    stray_en = 0;
    done_delay = 1;
    cyc(4);
    wait_idle("random");
    cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
